// File: rtl/bypass_history.sv
// Operand bypass history: a DEPTH-deep shift record of writeback results, with
// NUM_RD lookup ports that pick the youngest match. Define BYPASS_STATS_EN to add hit_cnt.
module bypass_history #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 3,
  parameter int NUM_RD = 2
) (
  input  logic                     clk,
  input  logic                     arst_n,
  input  logic                     stall,
  input  logic                     flush,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  input  logic [NUM_RD*DATA_W-1:0] rf_data,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_hit,
  output logic [NUM_RD*4-1:0]      rd_src
`ifdef BYPASS_STATS_EN
  ,
  output logic [NUM_RD*16-1:0]     hit_cnt
`endif
);

  logic              slot_vld  [DEPTH];
  logic [ADDR_W-1:0] slot_addr [DEPTH];
  logic [DATA_W-1:0] slot_data [DEPTH];

  // Flush only clears valid bits; stale addr/data are never observed.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      for (int k = 0; k < DEPTH; k++) begin
        slot_vld[k]  <= 1'b0;
        slot_addr[k] <= '0;
        slot_data[k] <= '0;
      end
    end else if (flush) begin
      for (int k = 0; k < DEPTH; k++) slot_vld[k] <= 1'b0;
    end else if (!stall) begin
      slot_vld[0]  <= wr_en && (wr_addr != '0);
      slot_addr[0] <= wr_addr;
      slot_data[0] <= wr_data;
      for (int k = 1; k < DEPTH; k++) begin
        slot_vld[k]  <= slot_vld[k-1];
        slot_addr[k] <= slot_addr[k-1];
        slot_data[k] <= slot_data[k-1];
      end
    end
  end

  // Sources are applied lowest priority first so later assignments win.
  always_comb begin
    rd_data = rf_data;
    rd_hit  = '0;
    rd_src  = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      for (int k = DEPTH - 1; k >= 0; k--) begin
        if (slot_vld[k] && (slot_addr[k] == rd_addr[p*ADDR_W +: ADDR_W])) begin
          rd_data[p*DATA_W +: DATA_W] = slot_data[k];
          rd_hit[p]                   = 1'b1;
          rd_src[p*4 +: 4]            = 4'(k + 2);
        end
      end
      if (wr_en && (wr_addr == rd_addr[p*ADDR_W +: ADDR_W])) begin
        rd_data[p*DATA_W +: DATA_W] = wr_data;
        rd_hit[p]                   = 1'b1;
        rd_src[p*4 +: 4]            = 4'd1;
      end
      if (rd_addr[p*ADDR_W +: ADDR_W] == '0) begin
        rd_data[p*DATA_W +: DATA_W] = '0;
        rd_hit[p]                   = 1'b0;
        rd_src[p*4 +: 4]            = 4'd0;
      end
    end
  end

`ifdef BYPASS_STATS_EN
  logic [15:0] cnt [NUM_RD];

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      for (int p = 0; p < NUM_RD; p++) cnt[p] <= '0;
    end else if (!stall) begin
      for (int p = 0; p < NUM_RD; p++)
        if (rd_hit[p] && (cnt[p] != 16'hFFFF)) cnt[p] <= cnt[p] + 16'd1;
    end
  end

  always_comb begin
    hit_cnt = '0;
    for (int p = 0; p < NUM_RD; p++) hit_cnt[p*16 +: 16] = cnt[p];
  end
`endif

endmodule
